// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered ownership and an optional hold-time limit.
// The one-hot grant is decoded from the registered owner index, so grant_o has
// no combinational path from request_i.

// Binary-tree one-hot decoder: each level splits every live node on one select
// bit, MSB first, so the leaves come out in natural index order.
module tree_decoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         enable_i,
    input  logic [W-1:0] select_i,
    output logic [N-1:0] onehot_o
);

    for (genvar l = 0; l < W; l++) begin : g_lvl
        logic [(2**(l+1))-1:0] node;
        for (genvar j = 0; j < 2**l; j++) begin : g_node
            logic parent;
            if (l == 0) begin : g_root
                assign parent = enable_i;
            end else begin : g_inner
                assign parent = g_lvl[l-1].node[j];
            end
            assign node[2*j]   = parent & ~select_i[W-1-l];
            assign node[2*j+1] = parent &  select_i[W-1-l];
        end
    end

    assign onehot_o = g_lvl[W-1].node[N-1:0];

    // Leaves beyond N are unreachable because the index never exceeds N-1.
    if (N < 2**W) begin : g_spare
        logic unused_leaves;
        assign unused_leaves = ^g_lvl[W-1].node[(2**W)-1:N];
    end

endmodule

module round_robin_arbiter #(
    parameter  int REQUESTERS = 4,
    parameter  int MAX_HOLD   = 0,
    localparam int IDX_W      = $clog2((REQUESTERS > 2) ? REQUESTERS : 2)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REQUESTERS-1:0] request_i,
    output logic [REQUESTERS-1:0] grant_o,
    output logic [IDX_W-1:0]      grant_index_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    // Counter only has to reach MAX_HOLD-1 before the revoke fires.
    localparam int              HOLD_W    = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
    localparam bit              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(REQUESTERS - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                timeout_q, timeout_d;

    logic [REQUESTERS-1:0] hi_mask;
    logic [REQUESTERS-1:0] req_hi;
    logic [REQUESTERS-1:0] cand;
    logic [REQUESTERS-1:0] cand_low;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      idx_next;
    logic                  owner_req;

    // Positions at or above the pointer win before the wrapped-around ones.
    for (genvar i = 0; i < REQUESTERS; i++) begin : g_hi
        assign hi_mask[i] = (ptr_q <= IDX_W'(i));
    end

    assign req_hi   = request_i & hi_mask;
    assign cand     = (|req_hi) ? req_hi : request_i;
    assign cand_low = cand & (~cand + REQUESTERS'(1));

    // Encode the isolated lowest set bit into a binary index.
    for (genvar b = 0; b < IDX_W; b++) begin : g_enc
        logic [REQUESTERS-1:0] bit_mask;
        for (genvar i = 0; i < REQUESTERS; i++) begin : g_m
            assign bit_mask[i] = 1'((i >> b) & 1);
        end
        assign win_idx[b] = |(cand_low & bit_mask);
    end

    // Pointer wraps at REQUESTERS, not at the power of two.
    assign idx_next  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    // grant_o is the owner's one-hot while busy, so this isolates its request.
    assign owner_req = |(request_i & grant_o);

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // Arbitrate in IDLE; in GRANT watch for release first, then the hold limit.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|request_i) begin
                    state_d = GRANT;
                    idx_d   = win_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    ptr_d   = idx_next;
                end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
                    state_d   = IDLE;
                    ptr_d     = idx_next;
                    timeout_d = 1'b1;
                end else if (HOLD_EN) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = (state_q == GRANT);
    assign grant_index_o = idx_q;
    assign timeout_o     = timeout_q;

    tree_decoder #(
        .N (REQUESTERS),
        .W (IDX_W)
    ) u_dec (
        .enable_i (busy_o),
        .select_i (idx_q),
        .onehot_o (grant_o)
    );

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboarded bench: three arbiter configurations share one stimulus loop;
// a reference model predicts every cycle and a monitor compares.
module tb_round_robin_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] req_a;
    logic [2:0] req_b;
    logic       req_c;

    logic [3:0] ga;  logic [1:0] ia;  logic ba, ta;
    logic [2:0] gb;  logic [1:0] ib;  logic bb, tb_;
    logic [0:0] gc;  logic [0:0] ic;  logic bc, tc;

    round_robin_arbiter #(.REQUESTERS(4), .MAX_HOLD(5)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .request_i(req_a),
        .grant_o(ga), .grant_index_o(ia), .busy_o(ba), .timeout_o(ta));

    round_robin_arbiter #(.REQUESTERS(3), .MAX_HOLD(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .request_i(req_b),
        .grant_o(gb), .grant_index_o(ib), .busy_o(bb), .timeout_o(tb_));

    round_robin_arbiter #(.REQUESTERS(1), .MAX_HOLD(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .request_i(req_c),
        .grant_o(gc), .grant_index_o(ic), .busy_o(bc), .timeout_o(tc));

    // Packed expectation per DUT: {timeout, busy, idx[1:0], grant[3:0]}
    typedef struct packed {
        logic [2:0][7:0] e;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    // Reference model state, one slot per DUT
    bit m_busy[3];
    bit m_to[3];
    int m_idx[3];
    int m_ptr[3];
    int m_hold[3];
    int m_timeouts = 0;

    function automatic logic [7:0] exp_pack(input int d);
        logic [3:0] g;
        g = m_busy[d] ? 4'(1 << m_idx[d]) : 4'b0;
        return {m_to[d], m_busy[d], 2'(m_idx[d]), g};
    endfunction

    function automatic logic [7:0] act_pack(input int d);
        case (d)
            0:       return {ta, ba, ia, ga};
            1:       return {tb_, bb, ib, 1'b0, gb};
            default: return {tc, bc, 1'b0, ic, 3'b0, gc};
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_busy[d] = 0; m_to[d] = 0; m_idx[d] = 0; m_ptr[d] = 0; m_hold[d] = 0;
        end
    endtask

    // One clock of arbitration, straight from the behavioural rules.
    task automatic model_step(input int d, input int n, input int hmax, input logic [3:0] req);
        m_to[d] = 0;
        if (!m_busy[d]) begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (m_ptr[d] + k) % n;
                if (req[c]) begin
                    m_idx[d] = c; m_busy[d] = 1; m_hold[d] = 0;
                    break;
                end
            end
        end else if (!req[m_idx[d]]) begin
            m_busy[d] = 0;
            m_ptr[d]  = (m_idx[d] + 1) % n;
        end else if (hmax != 0 && m_hold[d] + 1 == hmax) begin
            m_busy[d] = 0;
            m_ptr[d]  = (m_idx[d] + 1) % n;
            m_to[d]   = 1;
            m_timeouts++;
        end else begin
            m_hold[d]++;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s t=%0t actual={to,busy,idx,grant}=%b expected=%b", name, $time, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then predict what the rising edge does.
    task automatic cycle(input logic rst, input logic [3:0] ra, input logic [2:0] rb, input logic rc);
        exp_t x;
        @(negedge clk);
        rst_n = rst; req_a = ra; req_b = rb; req_c = rc;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            model_step(0, 4, 5, ra);
            model_step(1, 3, 0, {1'b0, rb});
            model_step(2, 1, 0, {3'b0, rc});
        end
        for (int d = 0; d < 3; d++) x.e[d] = exp_pack(d);
        exp_q.push_back(x);
    endtask

    // Monitor: compare each DUT shortly after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cfg_r4_h5", act_pack(0), e.e[0]);
                check("cfg_r3_h0", act_pack(1), e.e[1]);
                check("cfg_r1_h0", act_pack(2), e.e[2]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] flip(input logic [3:0] v, input int w, input int p);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < w; i++)
            if ($urandom_range(0, p - 1) == 0) r[i] = ~r[i];
        return r;
    endfunction

    initial begin
        logic [3:0] ra, rb, rc;
        req_a = '0; req_b = '0; req_c = 1'b0;
        model_reset();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check("reset_state", act_pack(d), 8'h00);

        cycle(0, 4'b1111, 3'b111, 1'b1);
        cycle(1, 4'b1111, 3'b111, 1'b1);
        cycle(1, 4'b1111, 3'b111, 1'b1);
        cycle(1, 4'b1111, 3'b111, 1'b1);

        // Asynchronous reset in the middle of a grant
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) check("async_reset", act_pack(d), 8'h00);
        cycle(0, 4'b1111, 3'b111, 1'b1);
        cycle(1, 4'b1111, 3'b111, 1'b1);

        // Rotation: the current owner drops for one cycle
        for (int n = 0; n < 14; n++) begin
            ra = m_busy[0] ? (4'b1111 & ~4'(1 << m_idx[0])) : 4'b1111;
            rb = m_busy[1] ? (4'b0111 & ~4'(1 << m_idx[1])) : 4'b0111;
            rc = m_busy[2] ? 4'b0 : 4'b1;
            cycle(1, ra, rb[2:0], rc[0]);
        end

        // Idle, then late arrival / skip-and-wrap pattern
        cycle(1, 4'b0000, 3'b000, 1'b0);
        cycle(1, 4'b0000, 3'b000, 1'b0);
        cycle(1, 4'b0010, 3'b100, 1'b1);
        cycle(1, 4'b0011, 3'b101, 1'b1);
        cycle(1, 4'b0011, 3'b111, 1'b0);
        cycle(1, 4'b0001, 3'b011, 1'b0);
        cycle(1, 4'b0001, 3'b011, 1'b1);
        cycle(1, 4'b0100, 3'b000, 1'b1);
        cycle(1, 4'b0011, 3'b011, 1'b1);
        cycle(1, 4'b0011, 3'b011, 1'b1);

        // Timeout: two requesters held constant
        for (int n = 0; n < 16; n++) cycle(1, 4'b0101, 3'b101, 1'b1);
        // Release exactly in the fifth held cycle
        cycle(1, 4'b0000, 3'b000, 1'b0);
        cycle(1, 4'b0001, 3'b001, 1'b1);
        for (int n = 0; n < 4; n++) cycle(1, 4'b0001, 3'b001, 1'b1);
        cycle(1, 4'b0000, 3'b000, 1'b0);
        cycle(1, 4'b0000, 3'b000, 1'b0);

        // Randomized: fast churn, then long holds that hit the limit
        ra = 4'b0; rb = 4'b0; rc = 4'b0;
        for (int n = 0; n < 2000; n++) begin
            int p;
            p  = (n < 1000) ? 4 : 12;
            ra = flip(ra, 4, p);
            rb = flip(rb, 3, p);
            rc = flip(rc, 1, p);
            if (n == 1500) begin
                cycle(0, ra, rb[2:0], rc[0]);
                model_reset();
            end
            cycle(1, ra, rb[2:0], rc[0]);
        end

        repeat (2) @(posedge clk);
        #2;
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        vec_cnt++;
        if (m_timeouts == 0) begin
            err_cnt++;
            $display("FAIL timeout_coverage: %0d timeouts seen, required >0", m_timeouts);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Round-robin arbiter that shares a single resource among `REQUESTERS` clients. It holds a registered grant until the owner releases it. An optional hold-time limit revokes the grant after a fixed number of cycles. The one-hot grant vector is produced by a `tree_decoder` instance driven from the registered owner index. It sits in front of any shared bus, port or functional unit whose select lines are one-hot.

## Interface
- `REQUESTERS`, default 4: number of clients, ≥1. `IDX_W = $clog2(max(REQUESTERS, 2))`.
- `MAX_HOLD`, default 0: maximum consecutive granted cycles per ownership; 0 means unlimited.
- `clk_i`, input, 1: single clock, rising edge.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `request_i`, input, REQUESTERS: level request per client; the client holds it high for the whole transaction.
- `grant_o`, output, REQUESTERS: one-hot grant; all zero when idle. Output of `tree_decoder` with `enable_i = busy_o`, `select_i = grant_index_o`.
- `grant_index_o`, output, IDX_W: registered index of the current owner; holds the last value when idle.
- `busy_o`, output, 1: high while a grant is held.
- `timeout_o`, output, 1: one-cycle pulse on the cycle after the grant is revoked by `MAX_HOLD`.

## Operation
- State register: two states, IDLE and GRANT. Additional registers:
  - `ptr` (IDX_W): priority pointer.
  - `hold_cnt`: wide enough for `MAX_HOLD`.
- **IDLE, `request_i == 0`:** stay in IDLE.
- **IDLE, any request bit set:**
  - Winner = first set bit scanning `ptr`, `ptr+1`, … `REQUESTERS-1`, then 0 … `ptr-1`.
  - Load `grant_index_o` = winner, go to GRANT, clear `hold_cnt`.
- **GRANT, `request_i[grant_index_o] == 0` (release):**
  - Go to IDLE.
  - `ptr` = (`grant_index_o` + 1) mod `REQUESTERS`.
- **GRANT, owner still requesting, `MAX_HOLD != 0`, `hold_cnt == MAX_HOLD-1`:**
  - Revoke: go to IDLE, advance `ptr` exactly as on release, pulse `timeout_o`.
  - The revoked client competes again from the next IDLE cycle at lowest priority.
- **GRANT, otherwise:** stay in GRANT, increment `hold_cnt`. Other clients' requests are ignored; there is no preemption except timeout.
- **Width and wrap rules:**
  - Pointer arithmetic wraps at `REQUESTERS`, not at `2**IDX_W`. Indices ≥ `REQUESTERS` are never produced.
  - With `REQUESTERS = 1`: `IDX_W = 1`, index is always 0, and `ptr` stays 0.
- **Simultaneous events:**
  - Release and timeout in the same cycle: treated as a release; no `timeout_o` pulse.
  - Requests from non-owners arriving during GRANT: only sampled in IDLE.
- **Reset (any time, including mid-grant):** state IDLE, `ptr = 0`, `grant_index_o = 0`, `hold_cnt = 0`. All outputs go low immediately and asynchronously.

## Timing
- Reset values: `grant_o = 0`, `grant_index_o = 0`, `busy_o = 0`, `timeout_o = 0`.
- Grant latency: request seen high in IDLE at edge k; `grant_o`, `busy_o` and `grant_index_o` valid after edge k.
- Release latency: owner drops its request before edge m; `grant_o = 0` and `busy_o = 0` after edge m.
- Minimum one IDLE cycle between consecutive grants. Back-to-back ownership changes take 2 cycles per handover.
- Timeout: grant is high for exactly `MAX_HOLD` cycles. `timeout_o` is high for one cycle, coincident with the first IDLE cycle.
- `grant_o` is purely combinational from registers, so there is no glitch path from `request_i`.
- Reset deassertion: the first arbitration happens at the first rising edge with `rst_ni` high.

## Test plan
- **Reset:** `REQUESTERS=4`, `request_i=4'b1111`, pulse `rst_ni` low mid-grant → `grant_o=0`, `busy_o=0` immediately. First grant after release is `grant_o=4'b0001`, index 0.
- **Rotation:** hold `request_i=4'b1111`; each owner drops its request for 1 cycle, then re-raises it → grants 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
- **Skip and wrap:** `ptr=3` (after owner 2 releases), `request_i=4'b0011` → grant index 0 (`grant_o=4'b0001`), not 1. `REQUESTERS=3`, owner 2 releases → `ptr` wraps to 0 and never reaches 3.
- **Timeout:** `MAX_HOLD=5`, `request_i=4'b0101` held constant.
  - Requester 0 gets `grant_o` for exactly 5 cycles, then `timeout_o` pulses once.
  - Requester 2 is granted on the next cycle.
  - Release in cycle 5 → no `timeout_o` pulse.
- **Single requester and idle:**
  - `REQUESTERS=1`, `request_i=1` → `grant_o=1`, index 0.
  - `request_i=0` → after 1 cycle, `grant_o=0`, `busy_o=0`, `grant_index_o` unchanged.
- **Late arrival:** owner 1 is granted, requester 0 raises its request mid-grant → `grant_o` stays 0010. After 1 releases, 0 is granted (pointer at 2, scan wraps to 0).
